// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
//   Sprite OAM DMA engine. A CPU write of a page number to $4014 stalls the CPU
//   and copies 256 bytes from {page,00}..{page,FF} into the PPU OAM data port
//   ($2004), one READ/WRITE bus pair per byte. Before the first READ there is
//   one DUMMY cycle, plus one ALIGN cycle when needed, so that every READ
//   falls on an even-parity cycle (odd_cycle = 0).
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   cpu_addr     CPU bus address        (used only while idle)
//   cpu_WE       CPU write strobe       (used only while idle)
//   cpu_data     CPU write data         (used only while idle)
//   mem_data_in  mapper read data, valid combinationally for bus_addr
//   bus_addr     address to the mapper
//   bus_WE       write strobe to the mapper
//   bus_data     write data to the mapper
//   cpu_stall    holds the CPU off the bus during a transfer
//   dma_active   high while a transfer owns the bus
// -----------------------------------------------------------------------------
module oam_dma (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_WE,
  input  logic [7:0]  cpu_data,
  input  logic [7:0]  mem_data_in,
  output logic [15:0] bus_addr,
  output logic        bus_WE,
  output logic [7:0]  bus_data,
  output logic        cpu_stall,
  output logic        dma_active
);

  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_DATA = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DUMMY = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        odd_cycle;
  logic [7:0]  page;
  logic [7:0]  count;
  logic [7:0]  data_latch;
  logic        trigger;

  // Only an idle engine listens to the CPU; a $4014 write mid-transfer is ignored.
  assign trigger = (state == IDLE) && cpu_WE && (cpu_addr == DMA_REG);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = DUMMY;
      // odd_cycle=1 here means the following cycle is even, so READ can start.
      DUMMY:   state_nxt = odd_cycle ? READ : ALIGN;
      ALIGN:   state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = (count == 8'hFF) ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer datapath: parity flop, page/count and the byte in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odd_cycle  <= 1'b0;
      page       <= 8'h00;
      count      <= 8'h00;
      data_latch <= 8'h00;
    end else begin
      odd_cycle <= ~odd_cycle;
      if (trigger) begin
        page  <= cpu_data;
        count <= 8'h00;
      end
      if (state == READ) begin
        data_latch <= mem_data_in;
      end
      // count stays 8-bit so the source address never carries into page.
      if ((state == WRITE) && (count != 8'hFF)) begin
        count <= count + 8'd1;
      end
    end
  end

  // Output logic
  always_comb begin
    bus_addr   = cpu_addr;
    bus_WE     = cpu_WE;
    bus_data   = cpu_data;
    cpu_stall  = 1'b0;
    dma_active = 1'b0;
    case (state)
      IDLE: begin
        bus_addr = cpu_addr;
        bus_WE   = cpu_WE;
        bus_data = cpu_data;
      end
      DUMMY, ALIGN: begin
        bus_addr   = DMA_REG;
        bus_WE     = 1'b0;
        bus_data   = data_latch;
        cpu_stall  = 1'b1;
        dma_active = 1'b1;
      end
      READ: begin
        bus_addr   = {page, count};
        bus_WE     = 1'b0;
        bus_data   = data_latch;
        cpu_stall  = 1'b1;
        dma_active = 1'b1;
      end
      WRITE: begin
        bus_addr   = OAM_DATA;
        bus_WE     = 1'b1;
        bus_data   = data_latch;
        cpu_stall  = 1'b1;
        dma_active = 1'b1;
      end
      default: begin
        bus_addr = cpu_addr;
        bus_WE   = cpu_WE;
        bus_data = cpu_data;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
//   Randomized bench for oam_dma. A transfer is modelled as a timeline: offset
//   k counts cycles from the DUMMY cycle, the first `base` offsets are the
//   DUMMY/ALIGN preamble (base = 1 or 2 from the cycle parity), and byte i is
//   read at offset base+2i and written at base+2i+1. Expected bus values are
//   derived from that arithmetic each cycle, and literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_oam_dma;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_WE;
  logic [7:0]  cpu_data;
  logic [7:0]  mem_data_in;
  logic [15:0] bus_addr;
  logic        bus_WE;
  logic [7:0]  bus_data;
  logic        cpu_stall;
  logic        dma_active;

  logic [7:0]  mem [65536];

  oam_dma dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_addr    (cpu_addr),
    .cpu_WE      (cpu_WE),
    .cpu_data    (cpu_data),
    .mem_data_in (mem_data_in),
    .bus_addr    (bus_addr),
    .bus_WE      (bus_WE),
    .bus_data    (bus_data),
    .cpu_stall   (cpu_stall),
    .dma_active  (dma_active)
  );

  assign mem_data_in = mem[bus_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Model state. Between a negedge and the next negedge, par is the parity of
  // the cycle that starts at the coming (or just passed) posedge.
  bit          par     = 1'b0;
  bit          m_act   = 1'b0;
  int          m_k     = 0;
  int          m_base  = 1;
  logic [7:0]  m_pg    = 8'h00;
  logic [7:0]  m_latch = 8'h00;

  // Per-transfer observations
  logic [15:0] rq[$];
  logic [7:0]  wq[$];
  int          n_pre    = 0;
  int          cur_len  = 0;
  int          last_len = 0;
  int          n_bursts = 0;
  bit          prev_stall = 1'b0;

  always @(negedge clk) begin
    logic [26:0] act;
    logic [26:0] exp;
    int          j;
    act = {bus_addr, bus_WE, bus_data, cpu_stall, dma_active};
    if (!rst_n || !m_act) begin
      exp = {cpu_addr, cpu_WE, cpu_data, 2'b00};
    end else if (m_k < m_base) begin
      exp = {16'h4014, 1'b0, m_latch, 2'b11};
    end else begin
      j = m_k - m_base;
      if (j % 2 == 0) exp = {m_pg, 8'(j / 2), 1'b0, m_latch, 2'b11};
      else            exp = {16'h2004, 1'b1, m_latch, 2'b11};
    end
    chk("cycle", {5'd0, act}, {5'd0, exp});

    if (rst_n && dma_active) begin
      if (bus_WE) wq.push_back(bus_data);
      else if (bus_addr != 16'h4014) begin
        rq.push_back(bus_addr);
        chk("read_parity", {31'd0, par}, 32'd0);
      end else n_pre++;
    end
    if (cpu_stall) cur_len++;
    else if (cur_len > 0) begin
      last_len = cur_len;
      cur_len  = 0;
    end
    if (cpu_stall && !prev_stall) n_bursts++;
    prev_stall = cpu_stall;

    if (!rst_n) begin
      m_act   = 1'b0;
      m_latch = 8'h00;
      par     = 1'b0;
    end else begin
      if (!m_act) begin
        if (cpu_WE && cpu_addr == 16'h4014) begin
          m_act  = 1'b1;
          m_k    = 0;
          m_pg   = cpu_data;
          m_base = par ? 2 : 1;
        end
      end else begin
        if (m_k >= m_base && ((m_k - m_base) % 2 == 0))
          m_latch = mem[{m_pg, 8'((m_k - m_base) / 2)}];
        m_k++;
        if (m_k == 512 + m_base) m_act = 1'b0;
      end
      par = ~par;
    end
  end

  task automatic drive_rand(input bit allow_trig);
    cpu_addr = 16'($urandom);
    if (cpu_addr == 16'h4014) cpu_addr = 16'h0000;
    cpu_WE   = 1'($urandom);
    cpu_data = 8'($urandom);
    if (allow_trig && ($urandom_range(0, 3) == 0)) begin
      cpu_addr = 16'h4014;
      cpu_WE   = 1'b1;
      cpu_data = 8'h07;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      drive_rand(1'b0);
    end
  endtask

  // dp is the required parity of the DUMMY cycle, i.e. the inverse of the
  // trigger cycle's parity.
  task automatic trig(input logic [7:0] pg, input bit dp);
    int t;
    t = 0;
    @(posedge clk); #2;
    while ((par == dp) && (t < 4)) begin
      drive_rand(1'b0);
      @(posedge clk); #2;
      t++;
    end
    rq.delete();
    wq.delete();
    n_pre    = 0;
    last_len = 0;
    cpu_addr = 16'h4014;
    cpu_WE   = 1'b1;
    cpu_data = pg;
  endtask

  task automatic wait_done(input bit retrig);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 700 && !done; c++) begin
      @(posedge clk); #2;
      if (!cpu_stall) begin
        done = 1'b1;
        drive_rand(1'b0);
      end else drive_rand(retrig);
    end
    if (!done) chk("dma_timeout", 32'd0, 32'd1);
    @(negedge clk); #1;
  endtask

  initial begin
    int bad;
    int b0;
    bit dp;
    logic [7:0] pg;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

    rst_n    = 1'b1;
    cpu_addr = 16'h1111;
    cpu_WE   = 1'b0;
    cpu_data = 8'h33;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_stall",  {31'd0, cpu_stall},  32'd0);
    chk("reset_active", {31'd0, dma_active}, 32'd0);
    chk("reset_addr",   {16'd0, bus_addr},   32'h1111);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle pass-through literal
    cpu_addr = 16'h0123; cpu_WE = 1'b1; cpu_data = 8'h5A;
    #1;
    chk("idle_addr",  {16'd0, bus_addr},  32'h0123);
    chk("idle_we",    {31'd0, bus_WE},    32'd1);
    chk("idle_data",  {24'd0, bus_data},  32'h5A);
    chk("idle_stall", {31'd0, cpu_stall}, 32'd0);
    idle_cycles(5);

    // Page 02 with DUMMY on an odd cycle: no ALIGN, 513 stall cycles
    trig(8'h02, 1'b1);
    wait_done(1'b0);
    chk("p02_len",   last_len,   32'd513);
    chk("p02_pre",   n_pre,      32'd1);
    chk("p02_nread", rq.size(),  32'd256);
    chk("p02_nwr",   wq.size(),  32'd256);
    for (int i = 0; i < 256 && i < rq.size() && i < wq.size(); i++) begin
      chk("p02_raddr", {16'd0, rq[i]}, 32'h0200 + i);
      chk("p02_wdata", {24'd0, wq[i]}, {24'd0, 8'(i) ^ 8'hA5});
    end
    idle_cycles(3);

    // DUMMY on an even cycle: ALIGN inserted, 514 stall cycles
    trig(8'h05, 1'b0);
    wait_done(1'b0);
    chk("p05_len", last_len,  32'd514);
    chk("p05_pre", n_pre,     32'd2);
    chk("p05_nwr", wq.size(), 32'd256);
    idle_cycles(3);

    // Page FF wraps to IDLE without touching 0000
    dp = 1'($urandom);
    trig(8'hFF, dp);
    wait_done(1'b0);
    chk("pff_len",   last_len,  dp ? 32'd513 : 32'd514);
    chk("pff_nread", rq.size(), 32'd256);
    if (rq.size() > 0) chk("pff_last", {16'd0, rq[rq.size() - 1]}, 32'hFFFF);
    bad = 0;
    foreach (rq[i]) if (rq[i] == 16'h0000) bad++;
    chk("pff_no_0000", bad, 32'd0);
    idle_cycles(3);

    // $4014 writes during a page-03 transfer are ignored
    b0 = n_bursts;
    trig(8'h03, 1'($urandom));
    wait_done(1'b1);
    idle_cycles(20);
    bad = 0;
    foreach (rq[i]) if (rq[i][15:8] != 8'h03) bad++;
    chk("p03_page",   bad,            32'd0);
    chk("p03_nwr",    wq.size(),      32'd256);
    chk("p03_bursts", n_bursts - b0,  32'd1);

    // Reset after the 100th WRITE aborts the transfer
    trig(8'h04, 1'($urandom));
    bad = 1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      if (wq.size() == 100) begin
        bad = 0;
        break;
      end
      drive_rand(1'b0);
    end
    chk("rst_reach100", bad, 32'd0);
    cpu_addr = 16'h1234; cpu_WE = 1'b0; cpu_data = 8'h99;
    rst_n = 1'b0;
    #1;
    chk("rst_stall",  {31'd0, cpu_stall},  32'd0);
    chk("rst_active", {31'd0, dma_active}, 32'd0);
    chk("rst_we",     {31'd0, bus_WE},     32'd0);
    chk("rst_addr",   {16'd0, bus_addr},   32'h1234);
    repeat (3) begin
      @(posedge clk); #2;
      drive_rand(1'b0);
    end
    rst_n = 1'b1;
    idle_cycles(40);
    chk("rst_nwr", wq.size(), 32'd100);

    // Random pages and parities, checked cycle by cycle against the model
    for (int t = 0; t < 3; t++) begin
      pg = 8'($urandom);
      dp = 1'($urandom);
      trig(pg, dp);
      wait_done(1'($urandom));
      chk("rand_len", last_len,  dp ? 32'd513 : 32'd514);
      chk("rand_nwr", wq.size(), 32'd256);
      idle_cycles($urandom_range(1, 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
